// File: rtl/aclk_pkg.sv
// Shared types and BCD limits for the alarm-clock datapath.
package aclk_pkg;

   typedef struct packed {
      logic [3:0] ms_hr;
      logic [3:0] ls_hr;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } bcd_time_t;

   localparam int         HOUR_MAX       = 23;
   localparam int         MIN_MAX        = 59;
   localparam logic [3:0] MAX_MS_HR      = 4'd2;
   localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
   localparam logic [3:0] MAX_MS_MIN     = 4'd5;
   localparam logic [3:0] MAX_BCD_DIGIT  = 4'd9;

   function automatic logic bcd_time_valid(input bcd_time_t t);
      logic v;
      v = (t.ms_hr <= MAX_MS_HR) && (t.ls_hr <= MAX_BCD_DIGIT) &&
          (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_BCD_DIGIT);
      if ((t.ms_hr == MAX_MS_HR) && (t.ls_hr > MAX_LS_HR_AT_2)) begin
         v = 1'b0;
      end else begin
         v = v;
      end
      return v;
   endfunction

endpackage

// File: rtl/aclk_bcd_add_min.sv
// Combinational BCD time + constant minutes, wrapping 59->00 (carry) and 23->00.
module aclk_bcd_add_min
   import aclk_pkg::*;
#(
   parameter int ADD_MIN = 5
)(
   input  bcd_time_t i_time,
   output bcd_time_t o_time
);

   logic [6:0] w_min_sum;
   logic [6:0] w_min;
   logic       w_carry;
   logic [4:0] w_hr_sum;
   logic [4:0] w_hr;

   always_comb begin
      w_min_sum = 7'(i_time.ms_min) * 7'd10 + 7'(i_time.ls_min) + 7'(ADD_MIN);
      if (w_min_sum > 7'(MIN_MAX)) begin
         w_min   = w_min_sum - 7'd60;
         w_carry = 1'b1;
      end else begin
         w_min   = w_min_sum;
         w_carry = 1'b0;
      end
      w_hr_sum = 5'(i_time.ms_hr) * 5'd10 + 5'(i_time.ls_hr) + {4'd0, w_carry};
      if (w_hr_sum > 5'(HOUR_MAX)) begin
         w_hr = 5'd0;
      end else begin
         w_hr = w_hr_sum;
      end
      o_time.ms_hr  = 4'(w_hr / 5'd10);
      o_time.ls_hr  = 4'(w_hr % 5'd10);
      o_time.ms_min = 4'(w_min / 7'd10);
      o_time.ls_min = 4'(w_min % 7'd10);
   end

endmodule

// File: rtl/aclk_alarm_bank.sv
// Multi-slot BCD alarm bank with validated edge-triggered loads, registered readback and ring flags.
// Snooze support is compiled in with `define ACLK_SNOOZE_EN.
module aclk_alarm_bank
   import aclk_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_new_a,
   input  logic [IDX_W-1:0]      load_idx,
   input  logic                  new_alarm_en,
   input  logic [3:0]            new_alarm_ms_hr,
   input  logic [3:0]            new_alarm_ls_hr,
   input  logic [3:0]            new_alarm_ms_min,
   input  logic [3:0]            new_alarm_ls_min,
   input  logic [3:0]            cur_ms_hr,
   input  logic [3:0]            cur_ls_hr,
   input  logic [3:0]            cur_ms_min,
   input  logic [3:0]            cur_ls_min,
   input  logic                  time_tick,
   input  logic                  stop_alarm,
`ifdef ACLK_SNOOZE_EN
   input  logic                  snooze,
`endif
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [3:0]            alarm_time_ms_hr,
   output logic [3:0]            alarm_time_ls_hr,
   output logic [3:0]            alarm_time_ms_min,
   output logic [3:0]            alarm_time_ls_min,
   output logic                  alarm_en_rd,
   output logic                  load_ack,
   output logic                  load_err,
   output logic [NUM_ALARMS-1:0] ring,
   output logic                  alarm_any
);

   localparam logic [IDX_W:0] NUM_W = NUM_ALARMS[IDX_W:0];

   if (NUM_ALARMS < 1 || NUM_ALARMS > 16 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_param_check
      $error("aclk_alarm_bank: parameter out of range");
   end

   bcd_time_t             r_time [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] r_en;
   logic [NUM_ALARMS-1:0] r_ring;
   logic                  r_alarm_any;
   logic                  r_load_prev;
   logic                  r_load_ack;
   logic                  r_load_err;
   bcd_time_t             r_rd_time;
   logic                  r_rd_en;

   bcd_time_t             w_cur;
   bcd_time_t             w_new;
   logic                  w_load_pulse;
   logic                  w_load_ok;
   logic [NUM_ALARMS-1:0] w_wr;
   logic [NUM_ALARMS-1:0] w_match;
   logic [NUM_ALARMS-1:0] w_ring_nxt;

   assign w_cur        = '{ms_hr: cur_ms_hr, ls_hr: cur_ls_hr, ms_min: cur_ms_min, ls_min: cur_ls_min};
   assign w_new        = '{ms_hr: new_alarm_ms_hr, ls_hr: new_alarm_ls_hr,
                           ms_min: new_alarm_ms_min, ls_min: new_alarm_ls_min};
   assign w_load_pulse = load_new_a & ~r_load_prev;
   assign w_load_ok    = bcd_time_valid(w_new) && ({1'b0, load_idx} < NUM_W);

`ifdef ACLK_SNOOZE_EN
   bcd_time_t             r_snz_time [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] r_snz_arm;
   bcd_time_t             w_snz_sum  [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] w_snz_hit;

   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_snz_add
      aclk_bcd_add_min #(.ADD_MIN(SNOOZE_MIN)) u_add (
         .i_time (w_cur),
         .o_time (w_snz_sum[g])
      );
   end
`endif

   // Per-slot write strobes, matches and the prioritised next ring state
   always_comb begin
      w_wr       = '0;
      w_match    = '0;
      w_ring_nxt = r_ring;
`ifdef ACLK_SNOOZE_EN
      w_snz_hit  = '0;
`endif
      for (int i = 0; i < NUM_ALARMS; i++) begin
         w_wr[i]    = w_load_pulse & w_load_ok & (load_idx == IDX_W'(i));
         w_match[i] = time_tick & r_en[i] & (r_time[i] == w_cur);
`ifdef ACLK_SNOOZE_EN
         w_snz_hit[i] = time_tick & r_en[i] & r_snz_arm[i] & (r_snz_time[i] == w_cur);
         if (w_wr[i] | stop_alarm | snooze) begin
            w_ring_nxt[i] = 1'b0;
         end else if (w_match[i] | w_snz_hit[i]) begin
            w_ring_nxt[i] = 1'b1;
         end else begin
            w_ring_nxt[i] = r_ring[i];
         end
`else
         if (w_wr[i] | stop_alarm) begin
            w_ring_nxt[i] = 1'b0;
         end else if (w_match[i]) begin
            w_ring_nxt[i] = 1'b1;
         end else begin
            w_ring_nxt[i] = r_ring[i];
         end
`endif
      end
   end

   // Slot storage, load handshake and ring flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_load_prev <= 1'b0;
         r_load_ack  <= 1'b0;
         r_load_err  <= 1'b0;
         r_ring      <= '0;
         r_alarm_any <= 1'b0;
         r_en        <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            r_time[i] <= '0;
         end
      end else begin
         r_load_prev <= load_new_a;
         r_load_ack  <= w_load_pulse & w_load_ok;
         r_load_err  <= w_load_pulse & ~w_load_ok;
         r_ring      <= w_ring_nxt;
         r_alarm_any <= |w_ring_nxt;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (w_wr[i]) begin
               r_time[i] <= w_new;
               r_en[i]   <= new_alarm_en;
            end
         end
      end
   end

`ifdef ACLK_SNOOZE_EN
   // Snooze arming: a ringing slot snoozed now re-rings at now + SNOOZE_MIN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_snz_arm <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            r_snz_time[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (w_wr[i] | stop_alarm) begin
               r_snz_arm[i] <= 1'b0;
            end else if (snooze) begin
               if (r_ring[i]) begin
                  r_snz_arm[i]  <= 1'b1;
                  r_snz_time[i] <= w_snz_sum[i];
               end
            end else if (w_snz_hit[i]) begin
               r_snz_arm[i] <= 1'b0;
            end
         end
      end
   end
`endif

   // Registered readback; out-of-range slots read as zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_time <= '0;
         r_rd_en   <= 1'b0;
      end else if ({1'b0, rd_idx} < NUM_W) begin
         r_rd_time <= r_time[rd_idx];
         r_rd_en   <= r_en[rd_idx];
      end else begin
         r_rd_time <= '0;
         r_rd_en   <= 1'b0;
      end
   end

   assign alarm_time_ms_hr  = r_rd_time.ms_hr;
   assign alarm_time_ls_hr  = r_rd_time.ls_hr;
   assign alarm_time_ms_min = r_rd_time.ms_min;
   assign alarm_time_ls_min = r_rd_time.ls_min;
   assign alarm_en_rd       = r_rd_en;
   assign load_ack          = r_load_ack;
   assign load_err          = r_load_err;
   assign ring              = r_ring;
   assign alarm_any         = r_alarm_any;

endmodule
